// File: rtl/leiwand_rv32_wb_interconnect_pkg.sv
// Shared constants and types for the Wishbone interconnect.
// Bus width, FSM encoding, width helper.
package leiwand_rv32_wb_interconnect_pkg;

  localparam int LEIWAND_MEM_WIDTH = 32;

  typedef enum logic [1:0] {
    WB_IC_IDLE     = 2'd0,
    WB_IC_WAIT_ACK = 2'd1,
    WB_IC_ERR_ACK  = 2'd2
  } wb_ic_state_e;

  // Bits needed to hold values 0..value (at least one).
  function automatic int high_bit_to_fit(input int value);
    int n;
    n = 1;
    while ((1 << n) <= value) n++;
    return n;
  endfunction

endpackage

// File: rtl/leiwand_rv32_wb_addr_decoder.sv
// Combinational slave address decoder.
// Lowest matching slot wins; offsets are addr - base.
module leiwand_rv32_wb_addr_decoder
  import leiwand_rv32_wb_interconnect_pkg::*;
#(
  parameter int N_SLAVES  = 2,
  parameter int MEM_WIDTH = LEIWAND_MEM_WIDTH,
  parameter int SEL_W     = 1,
  parameter logic [N_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE =
    {32'h20400000, 32'h10000000},
  parameter logic [N_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZE =
    {32'h1000, 32'h1000}
) (
  input  logic [MEM_WIDTH-1:0]          m_addr,
  output logic                          hit,
  output logic [SEL_W-1:0]              hit_idx,
  output logic [N_SLAVES*MEM_WIDTH-1:0] s_addr
);

  logic [N_SLAVES-1:0] in_rng;

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_slot
    localparam logic [MEM_WIDTH:0] BASE =
      {1'b0, SLAVE_BASE[i*MEM_WIDTH +: MEM_WIDTH]};
    localparam logic [MEM_WIDTH:0] SIZE =
      {1'b0, SLAVE_SIZE[i*MEM_WIDTH +: MEM_WIDTH]};
    logic [MEM_WIDTH:0] off;
    // one extra bit keeps the subtraction from wrapping
    assign off = {1'b0, m_addr} - BASE;
    assign in_rng[i] = ({1'b0, m_addr} >= BASE) && (off < SIZE);
    assign s_addr[i*MEM_WIDTH +: MEM_WIDTH] = off[MEM_WIDTH-1:0];
  end

  // priority select: scan down so the lowest index is written last
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (in_rng[i]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/leiwand_rv32_wb_interconnect.sv
// Pipelined Wishbone 1:N interconnect.
// One outstanding transfer, muxed return path, error and timeout acks.
module leiwand_rv32_wb_interconnect
  import leiwand_rv32_wb_interconnect_pkg::*;
#(
  parameter int N_SLAVES  = 2,
  parameter int MEM_WIDTH = LEIWAND_MEM_WIDTH,
  parameter logic [N_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE =
    {32'h20400000, 32'h10000000},
  parameter logic [N_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZE =
    {32'h1000, 32'h1000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          m_cyc,
  input  logic                          m_stb,
  input  logic                          m_we,
  input  logic [MEM_WIDTH-1:0]          m_addr,
  input  logic [MEM_WIDTH-1:0]          m_data_out,
  output logic [MEM_WIDTH-1:0]          m_data_in,
  output logic                          m_ack,
  output logic                          m_stall,
  output logic                          m_err,
  output logic [N_SLAVES-1:0]           s_cyc,
  output logic [N_SLAVES-1:0]           s_stb,
  output logic                          s_we,
  output logic [N_SLAVES*MEM_WIDTH-1:0] s_addr,
  output logic [MEM_WIDTH-1:0]          s_data_out,
  input  logic [N_SLAVES*MEM_WIDTH-1:0] s_data_in,
  input  logic [N_SLAVES-1:0]           s_ack,
  input  logic [N_SLAVES-1:0]           s_stall
);

  localparam int SEL_W = high_bit_to_fit(N_SLAVES - 1);
  localparam int CNT_W = high_bit_to_fit(TIMEOUT_CYCLES);
  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  wb_ic_state_e     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hit;
  logic [SEL_W-1:0] hit_idx;
  logic [MEM_WIDTH-1:0] rdata [N_SLAVES];

  leiwand_rv32_wb_addr_decoder #(
    .N_SLAVES  (N_SLAVES),
    .MEM_WIDTH (MEM_WIDTH),
    .SEL_W     (SEL_W),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_SIZE(SLAVE_SIZE)
  ) u_dec (
    .m_addr (m_addr),
    .hit    (hit),
    .hit_idx(hit_idx),
    .s_addr (s_addr)
  );

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_rd
    assign rdata[i] = s_data_in[i*MEM_WIDTH +: MEM_WIDTH];
  end

  assign s_we       = m_we;
  assign s_data_out = m_data_out;

  // state, selected slave and timeout counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= WB_IC_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state and bus outputs; all quiet while reset is held
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    s_cyc     = '0;
    s_stb     = '0;
    m_stall   = 1'b0;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    m_data_in = '0;
    if (reset) begin
      unique case (state_q)
        WB_IC_IDLE: begin
          if (m_cyc && m_stb) begin
            if (hit) begin
              s_cyc[hit_idx] = 1'b1;
              s_stb[hit_idx] = 1'b1;
              m_stall        = s_stall[hit_idx];
              if (!s_stall[hit_idx]) begin
                sel_d   = hit_idx;
                cnt_d   = '0;
                state_d = WB_IC_WAIT_ACK;
              end
            end else begin
              state_d = WB_IC_ERR_ACK;
            end
          end
        end
        WB_IC_WAIT_ACK: begin
          s_cyc[sel_q] = m_cyc;
          m_stall      = 1'b1;
          if (!m_cyc) begin
            state_d = WB_IC_IDLE;
          end else if (s_ack[sel_q]) begin
            m_ack     = 1'b1;
            m_data_in = rdata[sel_q];
            state_d   = WB_IC_IDLE;
          end else if (TO_EN && cnt_q == CNT_LAST) begin
            state_d = WB_IC_ERR_ACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WB_IC_ERR_ACK: begin
          m_stall = 1'b1;
          m_ack   = m_cyc;
          m_err   = m_cyc;
          state_d = WB_IC_IDLE;
        end
        default: state_d = WB_IC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_interconnect.sv
// Self-checking bench for the Wishbone interconnect.
// Directed spec cases plus random transfers against a range model.
module tb_leiwand_rv32_wb_interconnect;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           m_cyc, m_stb, m_we;
  logic [W-1:0]   m_addr, m_data_out, m_data_in;
  logic           m_ack, m_stall, m_err;
  logic [N-1:0]   s_cyc, s_stb;
  logic           s_we;
  logic [N*W-1:0] s_addr;
  logic [W-1:0]   s_data_out;
  logic [N*W-1:0] s_data_in;
  logic [N-1:0]   s_ack, s_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leiwand_rv32_wb_interconnect #(
    .N_SLAVES      (N),
    .MEM_WIDTH     (W),
    .SLAVE_BASE    ({32'h20400000, 32'h10000000}),
    .SLAVE_SIZE    ({32'h1000, 32'h1000}),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_addr(m_addr), .m_data_out(m_data_out),
    .m_data_in(m_data_in), .m_ack(m_ack),
    .m_stall(m_stall), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_addr(s_addr), .s_data_out(s_data_out),
    .s_data_in(s_data_in), .s_ack(s_ack),
    .s_stall(s_stall)
  );

  // memory map: slave k owns [base, base + 0x1000)
  function automatic logic [W-1:0] base_of(input int k);
    return (k == 0) ? 32'h10000000 : 32'h20400000;
  endfunction

  function automatic int decode(input logic [W-1:0] a);
    for (int k = 0; k < N; k++)
      if (a >= base_of(k) && a - base_of(k) < 32'h1000)
        return k;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    return (k < 0) ? '0 : N'(1 << k);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transfer; entered and left just after a rising edge.
  // delay: wait cycle of the slave ack (0 = slave never acks).
  task automatic txn(input logic [W-1:0] a, input logic we,
                     input int stall_n, input int delay,
                     input bit spur, input logic [W-1:0] rd);
    int k, c, exp_ack;
    logic exp_err;
    logic [W-1:0] exp_d;
    k = decode(a);
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = a; m_we = we;
    m_data_out = $urandom;
    s_ack = '0; s_stall = '0;
    s_data_in = {N{32'hFFFFFFFF}};
    if (k >= 0) begin
      s_data_in[k*W +: W] = rd;
      if (stall_n > 0) s_stall[k] = 1'b1;
    end
    c = 0;
    forever begin
      @(negedge clk);
      chk("req_stall", 64'(m_stall),
          64'(k >= 0 && c < stall_n));
      chk("req_stb", {s_cyc, s_stb}, {onehot(k), onehot(k)});
      chk("req_bcast", {s_we, s_data_out}, {we, m_data_out});
      chk("req_ack", 64'(m_ack), 64'(0));
      if (k >= 0)
        chk("req_addr", s_addr[k*W +: W], a - base_of(k));
      step();
      if (k < 0 || c >= stall_n) break;
      c++;
      if (c == stall_n) s_stall[k] = 1'b0;
    end
    m_stb = 1'b0;
    s_stall = '0;
    if (k < 0) begin
      exp_ack = 1; exp_err = 1'b1; exp_d = '0;
    end else if (delay >= 1 && delay <= TO) begin
      exp_ack = delay; exp_err = 1'b0; exp_d = rd;
    end else begin
      exp_ack = TO + 1; exp_err = 1'b1; exp_d = '0;
    end
    for (int j = 1; j <= exp_ack; j++) begin
      if (k >= 0 && j == delay) s_ack[k] = 1'b1;
      if (k >= 0 && spur) s_ack[1-k] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (j == exp_ack)
        chk("ack_resp", {m_ack, m_err, m_data_in},
            {1'b1, exp_err, exp_d});
      else
        chk("wait_resp", {m_ack, m_err, m_data_in}, 64'(0));
      if (j < exp_ack || !exp_err)
        chk("wait_cyc", {s_cyc, s_stb}, {onehot(k), 2'b00});
      step();
      s_ack = '0;
    end
  endtask

  initial begin
    int r, k;
    logic [W-1:0] a;
    reset = 1'b0;
    m_cyc = 0; m_stb = 0; m_we = 0;
    m_addr = '0; m_data_out = '0;
    s_data_in = '0; s_ack = '0; s_stall = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_out", {m_ack, m_err, m_stall, m_data_in},
        64'(0));
    chk("rst_slv", {s_cyc, s_stb}, 64'(0));
    step();
    reset = 1'b1;
    step();

    // read slave0, other slave drives all-ones
    txn(32'h10000010, 1'b0, 0, 1, 1'b0, 32'hDEADBEEF);
    // write slave1 top word, stalled three cycles
    txn(32'h20400FFC, 1'b1, 3, 2, 1'b0, 32'h0);
    // one past region end and address zero
    txn(32'h10001000, 1'b0, 0, 1, 1'b0, 32'h0);
    txn(32'h00000000, 1'b1, 0, 1, 1'b0, 32'h0);
    // slave0 never acks, then a late ack
    txn(32'h10000020, 1'b0, 0, 0, 1'b0, 32'h11111111);
    s_ack[0] = 1'b1;
    @(negedge clk);
    chk("late_ack", {m_ack, m_err}, 64'(0));
    step();
    s_ack = '0;
    txn(32'h10000024, 1'b0, 0, 2, 1'b0, 32'hCAFEF00D);
    // spurious acks from slave1, then back-to-back
    txn(32'h10000004, 1'b0, 0, 4, 1'b1, 32'hA5A5A5A5);
    txn(32'h10000008, 1'b0, 0, 1, 1'b0, 32'h01020304);
    txn(32'h20400008, 1'b0, 0, 1, 1'b1, 32'h05060708);

    // reset while waiting for an ack
    m_cyc = 1; m_stb = 1; m_addr = 32'h10000040;
    step();
    m_stb = 0;
    @(negedge clk);
    chk("wait_stall", 64'(m_stall), 64'(1));
    step();
    reset = 1'b0; m_cyc = 0;
    @(negedge clk);
    chk("rst_mid", {m_ack, m_err, m_stall, m_data_in},
        64'(0));
    chk("rst_mid_slv", {s_cyc, s_stb}, 64'(0));
    step();
    reset = 1'b1; m_cyc = 1; s_ack[0] = 1'b1;
    @(negedge clk);
    chk("rst_after", {m_ack, m_err, m_stall, s_cyc, s_stb},
        64'(0));
    step();
    s_ack = '0;

    // master drops cyc mid-wait
    m_stb = 1; m_addr = 32'h10000080;
    step();
    m_stb = 0;
    step();
    m_cyc = 0;
    @(negedge clk);
    chk("drop_cyc", {m_ack, s_cyc, s_stb}, 64'(0));
    step();
    s_ack[0] = 1'b1;
    @(negedge clk);
    chk("drop_ack", {m_ack, m_err}, 64'(0));
    step();
    s_ack = '0;
    txn(32'h20400100, 1'b0, 1, 3, 1'b1, 32'h76543210);

    // random transfers
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: a = 32'h10000000 + 32'($urandom_range(0, 1023) << 2);
        1: a = 32'h20400000 + 32'($urandom_range(0, 1023) << 2);
        2: begin
          k = $urandom_range(0, 3);
          a = (k == 0) ? 32'h10001000 :
              (k == 1) ? 32'h203FFFFC :
              (k == 2) ? 32'h20401000 : 32'h0FFFFFFC;
        end
        default: a = $urandom;
      endcase
      r = $urandom_range(0, 9);
      txn(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          (r == 0) ? 0 : $urandom_range(1, 4),
          1'($urandom_range(0, 1)), $urandom);
    end
    m_cyc = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
